// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and parity mode constants used by both the receive and transmit paths.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so an idle-high line does not look like a start edge out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling driven by an external
// sample_tick, optional parity, and break handling that waits for the line to return high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic ODD_MODE   = (PARITY_ODD != 0) ? UART_PARITY_ODD : UART_PARITY_EVEN;
  localparam logic PARITY_ON  = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  uart_state_e          state_r, state_next_s;
  logic [CNT_W-1:0]     tick_cnt_r, tick_cnt_next_s;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_next_s;
  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic                 par_err_r, par_err_next_s;
  logic                 load_s;
  logic                 rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // Frame state register and its datapath counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= CNT_ZERO;
      bit_cnt_r  <= CNT_ZERO;
      shift_r    <= '0;
      par_err_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      tick_cnt_r <= tick_cnt_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      shift_r    <= shift_next_s;
      par_err_r  <= par_err_next_s;
    end
  end

  // Next-state logic; every counter movement is gated by sample_tick.
  always_comb begin
    state_next_s    = state_r;
    tick_cnt_next_s = tick_cnt_r;
    bit_cnt_next_s  = bit_cnt_r;
    shift_next_s    = shift_r;
    par_err_next_s  = par_err_r;
    load_s          = 1'b0;
    if (sample_tick) begin
      case (state_r)
        ST_IDLE: begin
          tick_cnt_next_s = CNT_ZERO;
          if (!rx_s) begin
            state_next_s = ST_START;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_cnt_r == TICK_HALF) begin
            tick_cnt_next_s = CNT_ZERO;
            bit_cnt_next_s  = CNT_ZERO;
            state_next_s    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_next_s = tick_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_next_s = CNT_ZERO;
            shift_next_s    = {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_next_s = CNT_ZERO;
              state_next_s   = PARITY_ON ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_next_s = bit_cnt_r + CNT_ONE;
            end
          end else begin
            tick_cnt_next_s = tick_cnt_r + CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_next_s = CNT_ZERO;
            par_err_next_s  = (parity_of(8'(shift_r)) ^ rx_s) != ODD_MODE;
            state_next_s    = ST_STOP;
          end else begin
            tick_cnt_next_s = tick_cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_next_s = CNT_ZERO;
            load_s          = 1'b1;
            state_next_s    = rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            tick_cnt_next_s = tick_cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          tick_cnt_next_s = CNT_ZERO;
          if (rx_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_HIGH;
          end
        end
        default: begin
          state_next_s    = ST_IDLE;
          tick_cnt_next_s = CNT_ZERO;
          bit_cnt_next_s  = CNT_ZERO;
        end
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // Result register: data and flags update together on the stop-bit sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= load_s;
      busy     <= (state_next_s != ST_IDLE);
      if (load_s) begin
        rx_data    <= shift_r;
        parity_err <= PARITY_ON & par_err_r;
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule
